// File: rtl/program_loader_if.sv
// Load-port bundle: byte stream in, instruction-memory writes out, plus load control/status.
// The loader takes the master modport; the stream source / memory / CPU side takes slave.
interface program_loader_if #(
   parameter int unsigned WORD_SIZE  = 19,
   parameter int unsigned ADDR_WIDTH = 12
);
   logic                  start;
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [WORD_SIZE-1:0]  wr_data;
   logic                  cpu_en;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [ADDR_WIDTH-1:0] words_written;

   modport master (
      input  start, rx_data, rx_valid,
      output rx_ready, wr_en, wr_addr, wr_data, cpu_en, busy, done, error, words_written
   );

   modport slave (
      output start, rx_data, rx_valid,
      input  rx_ready, wr_en, wr_addr, wr_data, cpu_en, busy, done, error, words_written
   );
endinterface

// File: rtl/program_loader.sv
// Instruction-memory loader: parses a framed byte stream (length, 3-byte words, XOR checksum)
// into sequential memory writes and releases the CPU only after a clean, checksum-verified image.
module program_loader #(
   parameter int unsigned WORD_SIZE      = 19,
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned BYTES_PER_WORD = 3
) (
   input logic              clk,
   input logic              rst_n,
   program_loader_if.master bus
);
   localparam int unsigned LOW_BITS = 8 * (BYTES_PER_WORD - 1);
   localparam int unsigned HI_BITS  = WORD_SIZE - LOW_BITS;

   typedef enum logic [3:0] {
      IDLE, LEN_LO, LEN_HI, B0, B1, B2, WR, CHK, DONE_S, ERR_S
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] cnt_inc;
   logic [7:0]            chk_q, chk_d;
   logic [7:0]            b0_q, b0_d;
   logic [7:0]            b1_q, b1_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [WORD_SIZE-1:0]  wr_data_q, wr_data_d;
   logic                  rx_ready_q, rx_ready_d;
   logic                  wr_en_q, wr_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  cpu_en_q, cpu_en_d;
   logic                  xfer_c;
   logic [11:0]           len_full_c;

   assign xfer_c     = bus.rx_valid & rx_ready_q;
   assign len_full_c = {bus.rx_data[3:0], len_q[7:0]};
   assign cnt_inc    = ADDR_WIDTH'(cnt_q + 1'b1);

   // Next-state and next-register values; outputs are decoded from the next state so they register cleanly.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      chk_d     = chk_q;
      b0_d      = b0_q;
      b1_d      = b1_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      case (state_q)
         IDLE, DONE_S, ERR_S: begin
            if (bus.start) begin
               state_d = LEN_LO;
               cnt_d   = '0;
               chk_d   = '0;
            end
         end
         LEN_LO: begin
            if (xfer_c) begin
               len_d   = ADDR_WIDTH'(bus.rx_data);
               chk_d   = chk_q ^ bus.rx_data;
               state_d = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer_c) begin
               len_d = ADDR_WIDTH'(len_full_c);
               chk_d = chk_q ^ bus.rx_data;
               if (bus.rx_data[7:4] != 4'h0) state_d = ERR_S;
               else if (len_full_c == 12'h000) state_d = CHK;
               else state_d = B0;
            end
         end
         B0: begin
            if (xfer_c) begin
               b0_d    = bus.rx_data;
               chk_d   = chk_q ^ bus.rx_data;
               state_d = B1;
            end
         end
         B1: begin
            if (xfer_c) begin
               b1_d    = bus.rx_data;
               chk_d   = chk_q ^ bus.rx_data;
               state_d = B2;
            end
         end
         B2: begin
            if (xfer_c) begin
               // Upper bits of the last byte beyond the word width still feed the checksum.
               wr_addr_d = cnt_q;
               wr_data_d = {bus.rx_data[HI_BITS-1:0], b1_q, b0_q};
               chk_d     = chk_q ^ bus.rx_data;
               state_d   = WR;
            end
         end
         WR: begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == len_q) ? CHK : B0;
         end
         CHK: begin
            if (xfer_c) state_d = (bus.rx_data == chk_q) ? DONE_S : ERR_S;
         end
         default: state_d = IDLE;
      endcase

      rx_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == B0) ||
                   (state_d == B1) || (state_d == B2) || (state_d == CHK);
      wr_en_d    = (state_d == WR);
      busy_d     = rx_ready_d | wr_en_d;
      done_d     = (state_d == DONE_S);
      error_d    = (state_d == ERR_S);
      cpu_en_d   = done_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         cnt_q      <= '0;
         chk_q      <= '0;
         b0_q       <= '0;
         b1_q       <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rx_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         cpu_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         chk_q      <= chk_d;
         b0_q       <= b0_d;
         b1_q       <= b1_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rx_ready_q <= rx_ready_d;
         wr_en_q    <= wr_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         cpu_en_q   <= cpu_en_d;
      end
   end

   assign bus.rx_ready      = rx_ready_q;
   assign bus.wr_en         = wr_en_q;
   assign bus.wr_addr       = wr_addr_q;
   assign bus.wr_data       = wr_data_q;
   assign bus.cpu_en        = cpu_en_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.error         = error_q;
   assign bus.words_written = cnt_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random frames against a frame-level reference model.
module tb_program_loader;
   localparam int unsigned WORD_SIZE  = 19;
   localparam int unsigned ADDR_WIDTH = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   program_loader_if #(.WORD_SIZE(WORD_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   program_loader #(.WORD_SIZE(WORD_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .BYTES_PER_WORD(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  frame[$];
   logic [18:0] exp_d[$];
   int          log_a[$];
   logic [18:0] log_d[$];
   int          exp_need;
   int          exp_words;
   bit          exp_ok;

   always @(negedge clk) begin
      if (bus.wr_en) begin
         log_a.push_back(int'(bus.wr_addr));
         log_d.push_back(bus.wr_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
      check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
      check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
      check({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
      check({tag, "_cpu_en"},   32'(bus.cpu_en),   32'd0);
      check({tag, "_busy"},     32'(bus.busy),     32'd0);
      check({tag, "_done"},     32'(bus.done),     32'd0);
      check({tag, "_error"},    32'(bus.error),    32'd0);
      check({tag, "_words"},    32'(bus.words_written), 32'd0);
   endtask

   // Frame-level model: what the image means, independent of how the loader walks it.
   function automatic void predict();
      logic [7:0] hi;
      logic [7:0] x;
      int         n;
      exp_d.delete();
      hi = frame[1];
      if (hi[7:4] != 4'h0) begin
         exp_need  = 2;
         exp_ok    = 1'b0;
         exp_words = 0;
         return;
      end
      n = int'({hi[3:0], frame[0]});
      x = 8'h00;
      for (int i = 0; i < 2 + 3 * n; i++) x = x ^ frame[i];
      for (int w = 0; w < n; w++) begin
         logic [7:0] top;
         top = frame[2 + 3 * w + 2];
         exp_d.push_back({top[2:0], frame[2 + 3 * w + 1], frame[2 + 3 * w]});
      end
      exp_need  = 3 + 3 * n;
      exp_ok    = (frame[2 + 3 * n] == x);
      exp_words = n;
   endfunction

   function automatic void build(input int n, input bit bad);
      logic [7:0]  x;
      logic [18:0] w;
      frame.delete();
      frame.push_back(8'(n));
      frame.push_back(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         w = 19'($urandom);
         frame.push_back(w[7:0]);
         frame.push_back(w[15:8]);
         frame.push_back({5'($urandom), w[18:16]});
      end
      x = 8'h00;
      foreach (frame[i]) x = x ^ frame[i];
      frame.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
   endfunction

   task automatic run_frame(input string name, input int gap_pct, input int mid_start_cyc, input int abort_idx);
      int idx = 0;
      int cyc = 0;
      bit xfer;
      int n_log;
      predict();
      log_a.delete();
      log_d.delete();
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (idx < exp_need && cyc < 2000) begin
         bus.rx_valid = ($urandom_range(99) >= gap_pct);
         bus.rx_data  = bus.rx_valid ? frame[idx] : 8'($urandom);
         bus.start    = (cyc == mid_start_cyc);
         @(negedge clk);
         if (cyc == 0) begin
            check({name, "_start_busy"},  32'(bus.busy),          32'd1);
            check({name, "_start_words"}, 32'(bus.words_written), 32'd0);
            check({name, "_start_done"},  32'(bus.done | bus.error | bus.cpu_en), 32'd0);
         end
         if (abort_idx >= 0 && idx == abort_idx) break;
         xfer = bus.rx_valid && bus.rx_ready;
         @(posedge clk); #1;
         cyc++;
         if (xfer) idx++;
      end
      bus.rx_valid = 1'b0;
      bus.start    = 1'b0;
      if (abort_idx >= 0) begin
         rst_n = 1'b0;
         #1;
         check_all_zero({name, "_abort"});
         @(posedge clk); #1;
         rst_n = 1'b1;
         return;
      end
      check({name, "_consumed"}, 32'(idx), 32'(exp_need));
      if (gap_pct == 0 && exp_ok)
         check({name, "_latency"}, 32'(cyc), 32'(3 + 4 * exp_words));
      repeat (3) @(negedge clk);
      check({name, "_done"},     32'(bus.done),     32'(exp_ok));
      check({name, "_error"},    32'(bus.error),    32'(!exp_ok));
      check({name, "_cpu_en"},   32'(bus.cpu_en),   32'(exp_ok));
      check({name, "_busy"},     32'(bus.busy),     32'd0);
      check({name, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
      check({name, "_words"},    32'(bus.words_written), 32'(exp_words));
      n_log = log_d.size();
      check({name, "_n_writes"}, 32'(n_log), 32'(exp_d.size()));
      for (int i = 0; i < n_log && i < exp_d.size(); i++) begin
         check($sformatf("%s_addr%0d", name, i), 32'(log_a[i]), 32'(i));
         check($sformatf("%s_data%0d", name, i), 32'(log_d[i]), 32'(exp_d[i]));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bus.start    = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rst_n        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      frame = {8'h01, 8'h00, 8'hA5, 8'hA5, 8'h05, 8'h04};
      run_frame("t1", 0, -1, -1);
      check("t1_word", log_d.size() > 0 ? 32'(log_d[0]) : 32'hDEAD_BEEF, 32'h5A5A5);

      frame = {8'h01, 8'h00, 8'hA5, 8'hA5, 8'h05, 8'h05};
      run_frame("t2", 0, -1, -1);

      frame = {8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h07, 8'h07};
      run_frame("t3", 0, -1, -1);
      check("t3_word2", log_d.size() > 2 ? 32'(log_d[2]) : 32'hDEAD_BEEF, 32'h7FFFF);

      frame = {8'h00, 8'h00, 8'h00};
      run_frame("t4_empty", 0, -1, -1);

      frame = {8'h00, 8'h10};
      run_frame("t4_badlen", 0, -1, -1);

      frame = {8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h07, 8'h07};
      run_frame("t5_gaps", 35, 6, -1);

      run_frame("t6_abort", 0, -1, 3);
      frame = {8'h01, 8'h00, 8'hA5, 8'hA5, 8'h05, 8'h04};
      run_frame("t6_reload", 0, -1, -1);

      for (int r = 0; r < 20; r++) begin
         build($urandom_range(0, 6), $urandom_range(0, 3) == 0);
         run_frame($sformatf("rnd%0d", r), (r % 2 == 0) ? 0 : 30, (r % 3 == 0) ? 4 : -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
